fetch_seq_ctrl: RTL and testbench

// Fetch sequencer between the PC/BPU front end and the icache port. Owns the fetch PC, issues
// 2-wide fetch requests under valid/ready, tracks in-flight requests, discards stale responses

---
 rtl/fetch_seq_ctrl.sv | 165 ++++++++++++++++
 tb/tb_fetch_seq_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_seq_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues 2-wide icache requests, tracks in-flight requests
// and discards stale responses after a redirect. Optional perf counters: FETCH_PERF_CNT_EN.
module fetch_seq_ctrl #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h1c00_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flush,
  input  logic [31:0] branch_actual_addr,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  input  logic        ib_ready_i,
  output logic        req_valid_o,
  input  logic        req_ready_i,
  output logic [31:0] pc1,
  output logic [31:0] pc2,
  output logic        inst_en_1_o,
  output logic        inst_en_2_o,
  input  logic        resp_valid_i,
  input  logic [31:0] inst_1_i,
  input  logic [31:0] inst_2_i,
  output logic        fetch_valid_o,
  output logic [31:0] fetch_pc_o,
  output logic [31:0] fetch_inst_1_o,
  output logic [31:0] fetch_inst_2_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_req_cnt_o,
  output logic [31:0] perf_kill_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [1:0] MAX_OUT  = 2'(MAX_OUTSTANDING);
  localparam logic [1:0] LAST_IDX = 2'(MAX_OUTSTANDING - 1);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  outstanding_q, outstanding_d;
  logic [1:0]  kill_q, kill_d;
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [31:0] pcq_q [4];

  logic issue_ok;
  logic handshake;
  logic redirect_any;
  logic resp_take;
  logic drop_resp;

  assign redirect_any = branch_flush | redirect_i;
  // A response with nothing in flight is stray and must not touch the counters.
  assign resp_take    = resp_valid_i & (outstanding_q != 2'd0);
  assign drop_resp    = resp_take & ((kill_q != 2'd0) | redirect_any);
  assign handshake    = issue_ok & req_ready_i;

  // FSM next state and request qualification.
  always_comb begin
    state_d  = state_q;
    issue_ok = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        issue_ok = ~stall_i & ib_ready_i & (outstanding_q < MAX_OUT) & ~redirect_any;
        if (kill_d != 2'd0) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (kill_d == 2'd0) state_d = ST_FETCH;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // Counter, PC and queue-pointer next state.
  always_comb begin
    outstanding_d = outstanding_q;
    if (handshake && !resp_take)      outstanding_d = outstanding_q + 2'd1;
    else if (!handshake && resp_take) outstanding_d = outstanding_q - 2'd1;

    // The kill count covers everything still in flight once this cycle's traffic is settled.
    kill_d = kill_q;
    if (redirect_any)                        kill_d = outstanding_d;
    else if (resp_take && kill_q != 2'd0)    kill_d = kill_q - 2'd1;

    pc_d = pc_q;
    if (branch_flush)    pc_d = branch_actual_addr & 32'hFFFF_FFFC;
    else if (redirect_i) pc_d = redirect_addr_i & 32'hFFFF_FFFC;
    else if (handshake)  pc_d = pc_q + (pc_q[2] ? 32'd4 : 32'd8);

    wr_ptr_d = wr_ptr_q;
    if (handshake) wr_ptr_d = (wr_ptr_q == LAST_IDX) ? 2'd0 : wr_ptr_q + 2'd1;

    rd_ptr_d = rd_ptr_q;
    if (resp_take) rd_ptr_d = (rd_ptr_q == LAST_IDX) ? 2'd0 : rd_ptr_q + 2'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      outstanding_q <= 2'd0;
      kill_q        <= 2'd0;
      wr_ptr_q      <= 2'd0;
      rd_ptr_q      <= 2'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      kill_q        <= kill_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // NOTE: the PC queue storage is deliberately not reset; the pointers and count gate every read.
  always_ff @(posedge clk) begin
    if (handshake) pcq_q[wr_ptr_q] <= pc_q;
  end

  assign req_valid_o    = issue_ok;
  assign pc1            = pc_q;
  assign pc2            = pc_q + 32'd4;
  assign inst_en_1_o    = issue_ok;
  assign inst_en_2_o    = issue_ok & ~pc_q[2];
  assign fetch_valid_o  = resp_take & ~drop_resp;
  assign fetch_pc_o     = pcq_q[rd_ptr_q];
  assign fetch_inst_1_o = inst_1_i;
  assign fetch_inst_2_o = inst_2_i;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_req_q, perf_req_d;
  logic [31:0] perf_kill_q, perf_kill_d;

  always_comb begin
    perf_req_d  = perf_req_q + (handshake ? 32'd1 : 32'd0);
    perf_kill_d = perf_kill_q + (drop_resp ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_req_q  <= 32'd0;
      perf_kill_q <= 32'd0;
    end else begin
      perf_req_q  <= perf_req_d;
      perf_kill_q <= perf_kill_d;
    end
  end

  assign perf_req_cnt_o  = perf_req_q;
  assign perf_kill_cnt_o = perf_kill_q;
`endif

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Directed bench for fetch_seq_ctrl: request-side checks per cycle, response-side checks
// through a scoreboard queue drained by an independent monitor.
module tb_fetch_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, branch_flush, redirect_i, ib_ready_i, req_ready_i, resp_valid_i;
  logic [31:0] branch_actual_addr, redirect_addr_i, inst_1_i, inst_2_i;
  logic        req_valid_o, inst_en_1_o, inst_en_2_o, fetch_valid_o;
  logic [31:0] pc1, pc2, fetch_pc_o, fetch_inst_1_o, fetch_inst_2_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_req_cnt_o, perf_kill_cnt_o;
`endif

  fetch_seq_ctrl dut (
    .clk                (clk),
    .rst                (rst),
    .stall_i            (stall_i),
    .branch_flush       (branch_flush),
    .branch_actual_addr (branch_actual_addr),
    .redirect_i         (redirect_i),
    .redirect_addr_i    (redirect_addr_i),
    .ib_ready_i         (ib_ready_i),
    .req_valid_o        (req_valid_o),
    .req_ready_i        (req_ready_i),
    .pc1                (pc1),
    .pc2                (pc2),
    .inst_en_1_o        (inst_en_1_o),
    .inst_en_2_o        (inst_en_2_o),
    .resp_valid_i       (resp_valid_i),
    .inst_1_i           (inst_1_i),
    .inst_2_i           (inst_2_i),
    .fetch_valid_o      (fetch_valid_o),
    .fetch_pc_o         (fetch_pc_o),
    .fetch_inst_1_o     (fetch_inst_1_o),
    .fetch_inst_2_o     (fetch_inst_2_o)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_req_cnt_o     (perf_req_cnt_o),
    .perf_kill_cnt_o    (perf_kill_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] i1;
    logic [31:0] i2;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Request-side expectation for the current cycle, then advance to just after the next edge.
  task automatic step(input string name, input logic rv, input logic [31:0] p1, input logic en2);
    @(negedge clk);
    check(name, {req_valid_o, inst_en_1_o, inst_en_2_o, pc1, pc2},
          {rv, rv, en2, p1, p1 + 32'd4});
    @(posedge clk);
    #1;
    resp_valid_i = 1'b0;
  endtask

  // Present a response for the request at pc; live ones are expected at fetch_*.
  task automatic resp(input logic [31:0] pc, input logic live);
    exp_t e;
    resp_valid_i = 1'b1;
    inst_1_i     = ~pc;
    inst_2_i     = pc + 32'h0100_0001;
    if (live) begin
      e.pc = pc;
      e.i1 = ~pc;
      e.i2 = pc + 32'h0100_0001;
      sb.push_back(e);
    end
  endtask

  // Monitor: every forwarded response must match the oldest expected one.
  always @(negedge clk) begin
    if (fetch_valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL fetch_unexpected: got fetch_pc %0h, required no forwarded response",
                 fetch_pc_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("fetch_resp", {fetch_pc_o, fetch_inst_1_o, fetch_inst_2_o}, {e.pc, e.i1, e.i2});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    stall_i = 1'b0; branch_flush = 1'b0; redirect_i = 1'b0;
    ib_ready_i = 1'b1; req_ready_i = 1'b1; resp_valid_i = 1'b0;
    branch_actual_addr = 32'h0; redirect_addr_i = 32'h0;
    inst_1_i = 32'h0; inst_2_i = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    step("reset_req", 1'b0, 32'h1c00_0000, 1'b0);
    check("reset_fetch_valid", fetch_valid_o, 1'b0);
    rst = 1'b1;

    // 1: sequential fetch, icache latency 1
    step("t1_boot", 1'b0, 32'h1c00_0000, 1'b0);
    step("t1_req0", 1'b1, 32'h1c00_0000, 1'b1);
    resp(32'h1c00_0000, 1'b1);
    step("t1_req1", 1'b1, 32'h1c00_0008, 1'b1);
    resp(32'h1c00_0008, 1'b1);
    step("t1_req2", 1'b1, 32'h1c00_0010, 1'b1);
    req_ready_i = 1'b0;
    resp(32'h1c00_0010, 1'b1);
    step("t1_hold", 1'b1, 32'h1c00_0018, 1'b1);

    // 2: unaligned flush target, odd-word start
    branch_flush = 1'b1; branch_actual_addr = 32'h1c00_0006;
    step("t2_flush", 1'b0, 32'h1c00_0018, 1'b0);
    branch_flush = 1'b0; req_ready_i = 1'b1;
    step("t2_odd", 1'b1, 32'h1c00_0004, 1'b0);
    resp(32'h1c00_0004, 1'b1);
    step("t2_next", 1'b1, 32'h1c00_0008, 1'b1);

    // 3: flush with two in flight
    step("t3_fill", 1'b1, 32'h1c00_0010, 1'b1);
    branch_flush = 1'b1; branch_actual_addr = 32'h1c00_0100;
    step("t3_flush", 1'b0, 32'h1c00_0018, 1'b0);
    branch_flush = 1'b0;
    resp(32'h1c00_0008, 1'b0);
    step("t3_drain1", 1'b0, 32'h1c00_0100, 1'b0);
    resp(32'h1c00_0010, 1'b0);
    step("t3_drain2", 1'b0, 32'h1c00_0100, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    check("t3_perf_kill", perf_kill_cnt_o, 32'd2);
    check("t3_perf_req", perf_req_cnt_o, 32'd6);
`endif
    step("t3_target", 1'b1, 32'h1c00_0100, 1'b1);

    // 4: flush and redirect together; response in the flush cycle is dropped
    branch_flush = 1'b1; branch_actual_addr = 32'h1c00_0200;
    redirect_i   = 1'b1; redirect_addr_i    = 32'h1c00_0300;
    resp(32'h1c00_0100, 1'b0);
    step("t4_both", 1'b0, 32'h1c00_0108, 1'b0);
    branch_flush = 1'b0; redirect_i = 1'b0;
    step("t4_target", 1'b1, 32'h1c00_0200, 1'b1);

    // 5: outstanding limit, stall, withdrawn request
    step("t5_fill", 1'b1, 32'h1c00_0208, 1'b1);
    step("t5_full", 1'b0, 32'h1c00_0210, 1'b0);
    resp(32'h1c00_0200, 1'b1);
    step("t5_full_resp", 1'b0, 32'h1c00_0210, 1'b0);
    stall_i = 1'b1;
    resp(32'h1c00_0208, 1'b1);
    for (int i = 0; i < 5; i++) step("t5_stall", 1'b0, 32'h1c00_0210, 1'b0);
    stall_i = 1'b0; req_ready_i = 1'b0;
    resp_valid_i = 1'b1;
    step("t5_hold_stray", 1'b1, 32'h1c00_0210, 1'b1);
    ib_ready_i = 1'b0;
    step("t5_ib_withdraw", 1'b0, 32'h1c00_0210, 1'b0);
    ib_ready_i = 1'b1; req_ready_i = 1'b1;
    step("t5_reissue", 1'b1, 32'h1c00_0210, 1'b1);

    // 6: asynchronous reset with one in flight
    req_ready_i = 1'b0;
    step("t6_pre", 1'b1, 32'h1c00_0218, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("t6_async_req", {req_valid_o, inst_en_1_o, inst_en_2_o, pc1, pc2},
          {1'b0, 1'b0, 1'b0, 32'h1c00_0000, 32'h1c00_0004});
    check("t6_async_fetch_valid", fetch_valid_o, 1'b0);
    req_ready_i = 1'b1; resp_valid_i = 1'b1;
    step("t6_in_reset", 1'b0, 32'h1c00_0000, 1'b0);
    rst = 1'b1;
    resp_valid_i = 1'b1;
    step("t6_boot_stray", 1'b0, 32'h1c00_0000, 1'b0);
    step("t6_first", 1'b1, 32'h1c00_0000, 1'b1);
    req_ready_i = 1'b0;
    resp(32'h1c00_0000, 1'b1);
    step("t6_second", 1'b1, 32'h1c00_0008, 1'b1);
    step("t6_idle", 1'b1, 32'h1c00_0008, 1'b1);

    @(negedge clk);
    check("sb_drained", 128'(sb.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
